// File: rtl/ysyx_23060208_axi_pkg.sv
// Shared AXI4 read-channel definitions for the IFU/EXU read arbiter:
// payload layouts, field offsets, response codes, FSM encoding, watchdog default.
package ysyx_23060208_axi_pkg;

  localparam int unsigned AR_W        = 48;
  localparam int unsigned R_W         = 71;
  localparam int unsigned WD_W        = 8;
  localparam int unsigned TIMEOUT_DEF = 255;

  // AR payload field offsets (LSB positions)
  localparam int unsigned AR_ADDR_LSB = 16;
  localparam int unsigned AR_ID_LSB   = 12;
  localparam int unsigned AR_LEN_LSB  = 4;
  localparam int unsigned AR_SIZE_LSB = 1;
  localparam int unsigned AR_BURST_BIT = 0;

  // R payload field offsets (LSB positions)
  localparam int unsigned R_DATA_LSB = 7;
  localparam int unsigned R_RESP_LSB = 5;
  localparam int unsigned R_LAST_BIT = 4;
  localparam int unsigned R_ID_LSB   = 0;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  id;
    logic [7:0]  len;
    logic [2:0]  size;
    logic        burst;  // 1 = INCR, 0 = FIXED
  } ar_t;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } r_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_TERM = 2'd3
  } state_e;

endpackage

// File: rtl/ysyx_23060208_rr_pick.sv
// Two-requester round-robin picker (combinational).
//   req_i[1:0]    request vector (bit 0 = m0, bit 1 = m1)
//   last_grant_i  index of the master served most recently
//   gnt_o[1:0]    one-hot grant, zero when nobody requests
module ysyx_23060208_rr_pick (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o
);

  // On contention the master that was not served last wins.
  always_comb begin
    gnt_o = req_i;
    if (&req_i) begin
      gnt_o = last_grant_i ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/ysyx_23060208_rd_arbiter.sv
// Two-master / one-slave AXI4 read-channel arbiter with one outstanding
// transaction, round-robin grant, ownership-based R routing and a watchdog
// that self-completes hung transactions with SLVERR.
//   clock, reset            clock, asynchronous active-low reset
//   m0_* / m1_*             IFU / EXU AR and R channels (slave side of arbiter)
//   s_*                     shared memory read port (master side of arbiter)
//   err_timeout, err_beats  sticky error flags (watchdog expiry, beat/rlast mismatch)
module ysyx_23060208_rd_arbiter
  import ysyx_23060208_axi_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            m0_arvalid,
  output logic            m0_arready,
  input  logic [AR_W-1:0] m0_ar,
  output logic            m0_rvalid,
  input  logic            m0_rready,
  output logic [R_W-1:0]  m0_r,
  input  logic            m1_arvalid,
  output logic            m1_arready,
  input  logic [AR_W-1:0] m1_ar,
  output logic            m1_rvalid,
  input  logic            m1_rready,
  output logic [R_W-1:0]  m1_r,
  output logic            s_arvalid,
  input  logic            s_arready,
  output logic [AR_W-1:0] s_ar,
  input  logic            s_rvalid,
  output logic            s_rready,
  input  logic [R_W-1:0]  s_r,
  output logic            err_timeout,
  output logic            err_beats
);

  state_e          state_q, state_d;
  logic            gnt_q, gnt_d;              // owner of the current transaction
  logic            last_grant_q, last_grant_d;
  ar_t             ar_q, ar_d;
  logic [7:0]      len_q, len_d;
  logic [8:0]      beats_q, beats_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_to_q, err_to_d;
  logic            err_bt_q, err_bt_d;

  logic [1:0]      pick;
  logic            sel_rready;
  logic            wd_expired;
  r_t              term_r;

  ysyx_23060208_rr_pick u_pick (
    .req_i        ({m1_arvalid, m0_arvalid}),
    .last_grant_i (last_grant_q),
    .gnt_o        (pick)
  );

  assign sel_rready  = gnt_q ? m1_rready : m0_rready;
  assign wd_expired  = (wd_q == WD_W'(TIMEOUT));
  assign err_timeout = err_to_q;
  assign err_beats   = err_bt_q;

  // Self-generated error beat returned when the watchdog gives up.
  always_comb begin
    term_r      = '0;
    term_r.resp = RESP_SLVERR;
    term_r.last = 1'b1;
    term_r.id   = ar_q.id;
  end

  // Next-state and channel routing
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    ar_d         = ar_q;
    len_d        = len_q;
    beats_d      = beats_q;
    wd_d         = wd_q;
    err_to_d     = err_to_q;
    err_bt_d     = err_bt_q;
    s_arvalid    = 1'b0;
    s_ar         = '0;
    s_rready     = 1'b0;
    m0_arready   = 1'b0;
    m1_arready   = 1'b0;
    m0_rvalid    = 1'b0;
    m1_rvalid    = 1'b0;
    m0_r         = '0;
    m1_r         = '0;

    unique case (state_q)
      ST_IDLE: begin
        // Stray beats with nobody owning the bus are drained and flagged.
        s_rready = s_rvalid;
        if (s_rvalid) err_bt_d = 1'b1;
        if (pick != 2'b00) begin
          gnt_d   = pick[1];
          ar_d    = pick[1] ? ar_t'(m1_ar) : ar_t'(m0_ar);
          wd_d    = '0;
          state_d = ST_AR;
        end
      end

      ST_AR: begin
        s_rready = s_rvalid;
        if (s_rvalid) err_bt_d = 1'b1;
        if (wd_expired) begin
          err_to_d = 1'b1;
          state_d  = ST_TERM;
        end else begin
          s_arvalid  = 1'b1;
          s_ar       = ar_q;
          m0_arready = !gnt_q && s_arready;
          m1_arready = gnt_q && s_arready;
          if (s_arready) begin
            len_d   = ar_q.len;
            beats_d = '0;
            wd_d    = '0;
            state_d = ST_R;
          end else begin
            wd_d = wd_q + WD_W'(1);
          end
        end
      end

      ST_R: begin
        if (wd_expired) begin
          err_to_d = 1'b1;
          state_d  = ST_TERM;
        end else begin
          s_rready = sel_rready;
          if (gnt_q) begin
            m1_rvalid = s_rvalid;
            m1_r      = s_r;
          end else begin
            m0_rvalid = s_rvalid;
            m0_r      = s_r;
          end
          if (s_rvalid && sel_rready) begin
            wd_d    = '0;
            beats_d = beats_q + 9'd1;
            if (s_r[R_LAST_BIT]) begin
              // beats_q is the zero-based index of this beat; it must equal len.
              if (beats_q != {1'b0, len_q}) err_bt_d = 1'b1;
              last_grant_d = gnt_q;
              state_d      = ST_IDLE;
            end
          end else begin
            wd_d = wd_q + WD_W'(1);
          end
        end
      end

      ST_TERM: begin
        if (gnt_q) begin
          m1_rvalid = 1'b1;
          m1_r      = term_r;
        end else begin
          m0_rvalid = 1'b1;
          m0_r      = term_r;
        end
        if (sel_rready) begin
          last_grant_d = gnt_q;
          state_d      = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and bookkeeping registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
      ar_q         <= '0;
      len_q        <= '0;
      beats_q      <= '0;
      wd_q         <= '0;
      err_to_q     <= 1'b0;
      err_bt_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      ar_q         <= ar_d;
      len_q        <= len_d;
      beats_q      <= beats_d;
      wd_q         <= wd_d;
      err_to_q     <= err_to_d;
      err_bt_q     <= err_bt_d;
    end
  end

endmodule

// File: tb/tb_ysyx_23060208_rd_arbiter.sv
// Directed self-checking bench for ysyx_23060208_rd_arbiter.
module tb_ysyx_23060208_rd_arbiter;
  import ysyx_23060208_axi_pkg::*;

  logic            clock, reset;
  logic            m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic [AR_W-1:0] m0_ar;
  logic [R_W-1:0]  m0_r;
  logic            m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic [AR_W-1:0] m1_ar;
  logic [R_W-1:0]  m1_r;
  logic            s_arvalid, s_arready, s_rvalid, s_rready;
  logic [AR_W-1:0] s_ar;
  logic [R_W-1:0]  s_r;
  logic            err_timeout, err_beats;

  int errors = 0;
  int checks = 0;

  ysyx_23060208_rd_arbiter #(.TIMEOUT(255)) dut (
    .clock(clock), .reset(reset),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_ar(m0_ar),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_r(m0_r),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_ar(m1_ar),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_r(m1_r),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_ar(s_ar),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_r(s_r),
    .err_timeout(err_timeout), .err_beats(err_beats)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [AR_W-1:0] mk_ar(input logic [31:0] addr, input logic [3:0] id,
                                            input logic [7:0] len);
    logic [AR_W-1:0] v;
    v = '0;
    v[AR_ADDR_LSB +: 32] = addr;
    v[AR_ID_LSB +: 4]    = id;
    v[AR_LEN_LSB +: 8]   = len;
    v[AR_SIZE_LSB +: 3]  = 3'd2;
    v[AR_BURST_BIT]      = 1'b1;
    return v;
  endfunction

  function automatic logic [R_W-1:0] mk_r(input logic [63:0] data, input logic [1:0] resp,
                                          input logic last, input logic [3:0] id);
    logic [R_W-1:0] v;
    v = '0;
    v[R_DATA_LSB +: 64] = data;
    v[R_RESP_LSB +: 2]  = resp;
    v[R_LAST_BIT]       = last;
    v[R_ID_LSB +: 4]    = id;
    return v;
  endfunction

  task automatic step;
    @(negedge clock);
  endtask

  task automatic idle_inputs;
    m0_arvalid = 1'b0; m0_rready = 1'b0; m0_ar = '0;
    m1_arvalid = 1'b0; m1_rready = 1'b0; m1_ar = '0;
    s_arready = 1'b0; s_rvalid = 1'b0; s_r = '0;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    idle_inputs();
    step();
    reset = 1'b1;
    step();
  endtask

  // Slave model for one single-beat read; reports who was granted and routed.
  task automatic serve_one(input logic [63:0] data, output int who_ar, output int who_r,
                           output logic [AR_W-1:0] sar, output logic [R_W-1:0] got);
    int n;
    n = 0;
    who_ar = -1; who_r = -1; sar = '0; got = '0;
    s_arready = 1'b1;
    #1;
    while (s_arvalid !== 1'b1 && n < 20) begin
      step(); #1; n++;
    end
    if (s_arvalid !== 1'b1) return;
    sar = s_ar;
    who_ar = (m0_arready === 1'b1) ? 0 : ((m1_arready === 1'b1) ? 1 : -1);
    step();
    if (who_ar == 0) m0_arvalid = 1'b0;
    if (who_ar == 1) m1_arvalid = 1'b0;
    s_rvalid = 1'b1;
    s_r = mk_r(data, RESP_OKAY, 1'b1, sar[AR_ID_LSB +: 4]);
    m0_rready = 1'b1; m1_rready = 1'b1;
    #1;
    who_r = (m0_rvalid === 1'b1) ? 0 : ((m1_rvalid === 1'b1) ? 1 : -1);
    got = (who_r == 1) ? m1_r : m0_r;
    step();
    s_rvalid = 1'b0; m0_rready = 1'b0; m1_rready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    idle_inputs();
    step(); #1;
    checks++; if (s_arvalid !== 1'b0) begin errors++; $display("FAIL reset_s_arvalid: got %b want 0", s_arvalid); end
    checks++; if ({m0_arready, m1_arready, m0_rvalid, m1_rvalid, s_rready} !== 5'b0) begin errors++; $display("FAIL reset_handshakes: got %b want 00000", {m0_arready, m1_arready, m0_rvalid, m1_rvalid, s_rready}); end
    checks++; if ((s_ar | m0_r[47:0] | m1_r[47:0]) !== '0 || m0_r !== '0 || m1_r !== '0) begin errors++; $display("FAIL reset_payloads: got s_ar=%h m0_r=%h m1_r=%h want 0", s_ar, m0_r, m1_r); end
    checks++; if ({err_timeout, err_beats} !== 2'b00) begin errors++; $display("FAIL reset_err: got %b want 00", {err_timeout, err_beats}); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_single;
    logic [AR_W-1:0] ar;
    logic [R_W-1:0]  exp_r;
    ar = mk_ar(32'h8000_0000, 4'd1, 8'd0);
    exp_r = mk_r(64'h1234, RESP_OKAY, 1'b1, 4'd1);
    m0_ar = ar; m0_arvalid = 1'b1; s_arready = 1'b1;
    #1;
    checks++; if (s_arvalid !== 1'b0) begin errors++; $display("FAIL single_idle_arvalid: got %b want 0", s_arvalid); end
    step(); #1;
    checks++; if (s_arvalid !== 1'b1) begin errors++; $display("FAIL single_arvalid_latency: got %b want 1", s_arvalid); end
    checks++; if (s_ar !== ar) begin errors++; $display("FAIL single_s_ar: got %h want %h", s_ar, ar); end
    checks++; if ({m0_arready, m1_arready} !== 2'b10) begin errors++; $display("FAIL single_arready: got %b want 10", {m0_arready, m1_arready}); end
    step();
    m0_arvalid = 1'b0; m0_rready = 1'b1;
    s_rvalid = 1'b1; s_r = exp_r;
    #1;
    checks++; if (m0_rvalid !== 1'b1 || s_rready !== 1'b1) begin errors++; $display("FAIL single_r_handshake: got rvalid=%b s_rready=%b want 1 1", m0_rvalid, s_rready); end
    checks++; if (m0_r !== exp_r) begin errors++; $display("FAIL single_r_data: got %h want %h", m0_r, exp_r); end
    checks++; if (m1_rvalid !== 1'b0) begin errors++; $display("FAIL single_m1_rvalid: got %b want 0", m1_rvalid); end
    step();
    s_rvalid = 1'b0; m0_rready = 1'b0;
    #1;
    checks++; if ({m0_rvalid, m1_rvalid, s_arvalid, err_beats} !== 4'b0) begin errors++; $display("FAIL single_back_idle: got %b want 0000", {m0_rvalid, m1_rvalid, s_arvalid, err_beats}); end
    step();
  endtask

  task automatic test_simultaneous;
    logic [AR_W-1:0] ar0, ar1, sar;
    logic [R_W-1:0]  got;
    int wa, wr;
    do_reset();
    ar0 = mk_ar(32'h8000_0100, 4'd2, 8'd0);
    ar1 = mk_ar(32'h8000_0200, 4'd3, 8'd0);
    m0_ar = ar0; m1_ar = ar1; m0_arvalid = 1'b1; m1_arvalid = 1'b1;
    serve_one(64'hA0A0, wa, wr, sar, got);
    checks++; if (wa != 0 || sar !== ar0) begin errors++; $display("FAIL simul_first_grant: got master %0d ar %h want 0 %h", wa, sar, ar0); end
    checks++; if (wr != 0 || got !== mk_r(64'hA0A0, RESP_OKAY, 1'b1, 4'd2)) begin errors++; $display("FAIL simul_first_r: got master %0d r %h want 0", wr, got); end
    m0_arvalid = 1'b1;  // m0 asks again while m1 is still waiting
    serve_one(64'hB1B1, wa, wr, sar, got);
    checks++; if (wa != 1 || sar !== ar1) begin errors++; $display("FAIL simul_second_grant: got master %0d ar %h want 1 %h", wa, sar, ar1); end
    checks++; if (wr != 1 || got !== mk_r(64'hB1B1, RESP_OKAY, 1'b1, 4'd3)) begin errors++; $display("FAIL simul_second_r: got master %0d r %h want 1", wr, got); end
    serve_one(64'hC2C2, wa, wr, sar, got);
    checks++; if (wa != 0 || wr != 0) begin errors++; $display("FAIL simul_third_grant: got %0d/%0d want 0/0", wa, wr); end
  endtask

  task automatic test_burst(input logic bad);
    logic [R_W-1:0] exp_r;
    int nb;
    nb = bad ? 3 : 4;
    m1_ar = mk_ar(32'h8000_1000, 4'd4, 8'd3); m1_arvalid = 1'b1; s_arready = 1'b1;
    step(); #1;
    checks++; if (m1_arready !== 1'b1 || m0_arready !== 1'b0) begin errors++; $display("FAIL burst_arready: got m0=%b m1=%b want 0 1", m0_arready, m1_arready); end
    step();
    m1_arvalid = 1'b0; m1_rready = 1'b1;
    for (int i = 0; i < nb; i++) begin
      exp_r = mk_r(64'h100 + 64'(i), RESP_OKAY, (i == nb - 1), 4'd4);
      s_rvalid = 1'b1; s_r = exp_r;
      #1;
      checks++; if (m1_rvalid !== 1'b1 || m1_r !== exp_r || m0_rvalid !== 1'b0) begin errors++; $display("FAIL burst_beat%0d: got rvalid=%b r=%h want 1 %h", i, m1_rvalid, m1_r, exp_r); end
      step();
    end
    s_rvalid = 1'b0; m1_rready = 1'b0;
    #1;
    checks++; if (m1_rvalid !== 1'b0 || s_arvalid !== 1'b0) begin errors++; $display("FAIL burst_idle_after: got rvalid=%b arvalid=%b want 0 0", m1_rvalid, s_arvalid); end
    checks++; if (err_beats !== bad) begin errors++; $display("FAIL burst_err_beats: got %b want %b", err_beats, bad); end
    step();
  endtask

  task automatic test_backpressure;
    logic [R_W-1:0] exp_r;
    exp_r = mk_r(64'hBEEF, RESP_OKAY, 1'b1, 4'd6);
    m1_ar = mk_ar(32'h8000_2000, 4'd6, 8'd0); m1_arvalid = 1'b1; s_arready = 1'b1;
    step(); step();
    m1_arvalid = 1'b0; m1_rready = 1'b0;
    s_rvalid = 1'b1; s_r = exp_r;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if (s_rready !== 1'b0 || m1_rvalid !== 1'b1) begin errors++; $display("FAIL bp_stall%0d: got s_rready=%b rvalid=%b want 0 1", i, s_rready, m1_rvalid); end
      step();
    end
    m1_rready = 1'b1;
    #1;
    checks++; if (s_rready !== 1'b1 || m1_r !== exp_r) begin errors++; $display("FAIL bp_release: got s_rready=%b r=%h want 1 %h", s_rready, m1_r, exp_r); end
    step();
    s_rvalid = 1'b0; m1_rready = 1'b0;
    #1;
    checks++; if (err_timeout !== 1'b0 || m1_rvalid !== 1'b0) begin errors++; $display("FAIL bp_no_timeout: got err_timeout=%b rvalid=%b want 0 0", err_timeout, m1_rvalid); end
    step();
  endtask

  task automatic test_timeout;
    logic [AR_W-1:0] sar;
    logic [R_W-1:0]  got;
    int n, wa, wr;
    s_arready = 1'b0;
    m0_ar = mk_ar(32'h8000_3000, 4'd5, 8'd0); m0_arvalid = 1'b1; m0_rready = 1'b0;
    step();
    n = 0;
    #1;
    while (s_arvalid === 1'b1 && n < 300) begin
      n++; step(); #1;
    end
    checks++; if (n != 255) begin errors++; $display("FAIL timeout_ar_cycles: got %0d want 255", n); end
    step();
    m0_arvalid = 1'b0;
    #1;
    checks++; if (m0_rvalid !== 1'b1 || m0_r !== mk_r(64'h0, RESP_SLVERR, 1'b1, 4'd5)) begin errors++; $display("FAIL timeout_term_resp: got rvalid=%b r=%h want 1 SLVERR", m0_rvalid, m0_r); end
    checks++; if (err_timeout !== 1'b1 || m1_rvalid !== 1'b0) begin errors++; $display("FAIL timeout_flag: got err_timeout=%b m1_rvalid=%b want 1 0", err_timeout, m1_rvalid); end
    step(); #1;
    checks++; if (m0_rvalid !== 1'b1) begin errors++; $display("FAIL timeout_term_hold: got %b want 1", m0_rvalid); end
    step();
    m0_rready = 1'b1;
    step();
    m0_rready = 1'b0;
    #1;
    checks++; if (m0_rvalid !== 1'b0) begin errors++; $display("FAIL timeout_term_done: got %b want 0", m0_rvalid); end
    step();
    m1_ar = mk_ar(32'h8000_3100, 4'd8, 8'd0); m1_arvalid = 1'b1;
    serve_one(64'h5555, wa, wr, sar, got);
    checks++; if (wa != 1 || wr != 1 || got !== mk_r(64'h5555, RESP_OKAY, 1'b1, 4'd8)) begin errors++; $display("FAIL timeout_next_req: got %0d/%0d r=%h want 1/1", wa, wr, got); end
  endtask

  task automatic test_reset_mid_r;
    logic [AR_W-1:0] sar;
    logic [R_W-1:0]  got;
    int wa, wr;
    m0_ar = mk_ar(32'h8000_4000, 4'd7, 8'd0); m0_arvalid = 1'b1; s_arready = 1'b1;
    step(); step();
    m0_arvalid = 1'b0; m0_rready = 1'b0;
    s_rvalid = 1'b1; s_r = mk_r(64'h7777, RESP_OKAY, 1'b1, 4'd7);
    #1;
    checks++; if (m0_rvalid !== 1'b1) begin errors++; $display("FAIL rst_pre_in_r: got %b want 1", m0_rvalid); end
    #2;
    reset = 1'b0; s_rvalid = 1'b0; s_arready = 1'b0;
    #1;
    checks++; if ({s_arvalid, s_rready, m0_rvalid, m1_rvalid, m0_arready, m1_arready} !== 6'b0) begin errors++; $display("FAIL rst_async_ctrl: got %b want 000000", {s_arvalid, s_rready, m0_rvalid, m1_rvalid, m0_arready, m1_arready}); end
    checks++; if (m0_r !== '0 || s_ar !== '0 || {err_timeout, err_beats} !== 2'b00) begin errors++; $display("FAIL rst_async_data: got m0_r=%h s_ar=%h err=%b want 0", m0_r, s_ar, {err_timeout, err_beats}); end
    step();
    reset = 1'b1;
    step();
    m0_ar = mk_ar(32'h8000_5000, 4'd9, 8'd0); m0_arvalid = 1'b1;
    serve_one(64'h9999, wa, wr, sar, got);
    checks++; if (wa != 0 || wr != 0 || got !== mk_r(64'h9999, RESP_OKAY, 1'b1, 4'd9)) begin errors++; $display("FAIL rst_fresh_read: got %0d/%0d r=%h want 0/0", wa, wr, got); end
    checks++; if (err_beats !== 1'b0) begin errors++; $display("FAIL rst_fresh_err: got %b want 0", err_beats); end
    s_rvalid = 1'b1; s_r = mk_r(64'hDEAD, RESP_OKAY, 1'b1, 4'd0);
    #1;
    checks++; if (s_rready !== 1'b1 || m0_rvalid !== 1'b0) begin errors++; $display("FAIL stray_ack: got s_rready=%b m0_rvalid=%b want 1 0", s_rready, m0_rvalid); end
    step();
    s_rvalid = 1'b0;
    #1;
    checks++; if (err_beats !== 1'b1) begin errors++; $display("FAIL stray_err_beats: got %b want 1", err_beats); end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_burst(1'b0);
    test_burst(1'b1);
    test_backpressure();
    test_timeout();
    test_reset_mid_r();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
